ahb_ram_slave: RTL and testbench
================================

# ahb_ram_slave

Synthesizable AHB-Lite responder that backs a word-organised on-chip RAM and completes transfers driven by the team's AHB master VIP and DUT masters. It samples address-phase controls, inserts a programmable number of wait states, and performs byte/halfword/word writes with byte-lane enables. Illegal accesses get the two-cycle AHB ERROR response. It is the slave end of the AHB RAM test environment; the VIP monitor observes it passively.

## Interface
- ADDR_WIDTH, 16, byte address width; RAM holds 2^(ADDR_WIDTH-2) 32-bit words
- DATA_WIDTH, 32, fixed; other values unsupported
- WAIT_STATES, 0, data-phase wait cycles per transfer, 0..7
- hclk  in  1  bus clock; all state updates on rising edge
- hreset  in  1  reset; asynchronous, active-high
- hsel  in  1  slave select, address phase
- haddr  in  ADDR_WIDTH  byte address, address phase
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- hwrite  in  1  1=write
- hsize  in  3  000 byte, 001 half, 010 word; others illegal
- hburst  in  3  accepted, not used for decode (every beat is decoded independently)
- hprot  in  4  ignored
- hwdata  in  32  write data, data phase
- hready  in  1  bus-level ready (hreadyin); address phase sampled only when 1
- hreadyout  out  1  slave ready; reset 1
- hresp  out  2  00 OKAY, 01 ERROR; reset 00
- hrdata  out  32  read data; reset 0

## Operation
- Transfer accepted at rising edge when hsel=1, hready=1, htrans[1]=1. Captures haddr, hwrite, hsize into data-phase registers.
- IDLE/BUSY, or hsel=0, with hready=1: no transfer. The next cycle is a zero-wait OKAY (hreadyout=1, hresp=00).
- Error check at acceptance. Any one of these is an error:
  - hsize > 010
  - misaligned address: half with haddr[0]=1, word with haddr[1:0]≠00
- An error access never modifies the RAM.
- States:
  - IDLE: hreadyout=1, hresp=00. Accept → WAIT if WAIT_STATES>0, else LAST. Error accept → ERR1.
  - WAIT: hreadyout=0, hresp=00. A counter loads WAIT_STATES-1 and decrements. At 0 → LAST.
  - LAST: hreadyout=1, hresp=00.
    - Write commits at this edge, using byte enables from the captured hsize and addr[1:0] (little-endian lanes).
    - Read: hrdata = mem[addr_q[ADDR_WIDTH-1:2]], full word, all lanes driven.
    - From LAST, a new accept at this same edge → WAIT/LAST/ERR1; otherwise → IDLE.
  - ERR1: hreadyout=0, hresp=01 → ERR2.
  - ERR2: hreadyout=1, hresp=01. A new accept is legal here, same as in LAST; otherwise → IDLE.
- hrdata is 0 outside a read LAST cycle.
- Read-after-write to the same word, back-to-back, returns the new data. The write commits at the edge that starts the read's data phase.
- hready=0 while hsel=1 and htrans=NONSEQ (another slave is stalling the bus): nothing is sampled and the state does not change.
- A new address phase presented while this slave's hreadyout=0 is not sampled. The master holds it, and it is accepted on the LAST/ERR2 edge.
- Reset asserted mid-transfer: state → IDLE at once, outputs go to their reset values, the pending write is dropped. RAM contents are not cleared.

## Timing
- OKAY transfer: data phase = WAIT_STATES+1 cycles, with hreadyout low for the first WAIT_STATES cycles.
- ERROR transfer: always 2 cycles, independent of WAIT_STATES.
- Sustained back-to-back throughput: 1 transfer per WAIT_STATES+1 cycles.
- Read data is combinational from the RAM, valid in the cycle where hreadyout=1.
- All outputs are registered, except hrdata, which is a combinational read of a registered address.

## Test plan
- Reset: hreset=1 mid-WAIT with WAIT_STATES=3 → hreadyout=1, hresp=00, hrdata=0 immediately. After release, a read of the pending write address returns the old data.
- WAIT_STATES=0: word write 0xDEADBEEF @0x0010, then back-to-back read @0x0010 → read data phase 1 cycle, hrdata=0xDEADBEEF.
- Byte/half lanes: word 0x00000000 @0x20; byte write 0xAA @0x21; half write 0x1234 @0x22; read @0x20 → 0x1234AA00.
- WAIT_STATES=2: two consecutive NONSEQ reads → hreadyout pattern 0,0,1,0,0,1; address 2 is held during the stall.
- Errors:
  - word write @0x0002 → hresp=01 for 2 cycles, hreadyout 0 then 1, RAM unchanged.
  - hsize=011 → same response.
- hready=0 with hsel=1 and htrans=NONSEQ → no accept, hreadyout stays 1, RAM unchanged.

Source files
------------

// File: rtl/ahb_ram_slave.sv
// AHB-Lite slave in front of a word-organised RAM: programmable data-phase wait
// states, byte/halfword/word writes on little-endian lanes, two-cycle ERROR.
module ahb_ram_slave #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic [1:0]            hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int unsigned WORDS     = 2 ** (ADDR_WIDTH - 2);
  localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;
  logic                  hreadyout_q, hreadyout_d;
  logic                  err_q, err_d;

  logic                  can_accept;
  logic                  accept;
  logic                  illegal;
  logic                  commit;
  logic [3:0]            be;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic                  unused_ok;
  assign unused_ok = ^{htrans[0], hburst, hprot};

  // A new address phase may only be taken in cycles where this slave drives hreadyout high.
  always_comb begin
    can_accept = (state_q == ST_IDLE) || (state_q == ST_LAST) || (state_q == ST_ERR2);
    accept     = can_accept && hready && hsel && htrans[1];
    illegal    = (hsize > 3'b010)
              || ((hsize == 3'b001) && haddr[0])
              || ((hsize == 3'b010) && (haddr[1:0] != 2'b00));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_LAST, ST_ERR2: begin
        if (hready) begin
          commit = (state_q == ST_LAST) && write_q;
          if (accept) begin
            addr_d  = haddr;
            write_d = hwrite && !illegal;
            size_d  = hsize[1:0];
            if (illegal) begin
              state_d = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
              state_d = ST_WAIT;
              cnt_d   = WAIT_LOAD;
            end else begin
              state_d = ST_LAST;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_LAST;
        end else begin
          cnt_d = 3'(cnt_q - 3'd1);
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered from the next state so they change exactly at the edge.
    hreadyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
    err_d       = (state_d == ST_ERR1) || (state_d == ST_ERR2);
  end

  always_comb begin
    be = 4'b0000;
    unique case (size_q)
      2'b00:   be = 4'b0001 << addr_q[1:0];
      2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
      hreadyout_q <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      size_q      <= size_d;
      hreadyout_q <= hreadyout_d;
      err_q       <= err_d;
    end
  end

  // RAM contents survive reset; commit is derived from state_q, so reset drops a pending write.
  always_ff @(posedge hclk) begin
    if (commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr_q[ADDR_WIDTH-1:2]][8*i +: 8] <= hwdata[8*i +: 8];
        end
      end
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = {1'b0, err_q};
  assign hrdata    = ((state_q == ST_LAST) && !write_q) ? mem[addr_q[ADDR_WIDTH-1:2]] : '0;

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Bench for ahb_ram_slave: three instances (0, 2 and 3 wait states) driven by a
// pipelined AHB master and checked against a byte-addressed memory model.
module tb_ahb_ram_slave;

  localparam int NI = 3;

  logic hclk = 1'b0;
  always #5 hclk = ~hclk;

  logic        hreset_a [NI];
  logic        hsel_a   [NI];
  logic [15:0] haddr_a  [NI];
  logic [1:0]  htrans_a [NI];
  logic        hwrite_a [NI];
  logic [2:0]  hsize_a  [NI];
  logic [2:0]  hburst_a [NI];
  logic [3:0]  hprot_a  [NI];
  logic [31:0] hwdata_a [NI];
  logic        hready_a [NI];
  logic [NI-1:0]       hreadyout_v;
  logic [NI-1:0][1:0]  hresp_v;
  logic [NI-1:0][31:0] hrdata_v;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ahb_ram_slave #(
      .ADDR_WIDTH (16),
      .DATA_WIDTH (32),
      .WAIT_STATES((g == 0) ? 0 : g + 1)
    ) u_dut (
      .hclk     (hclk),
      .hreset   (hreset_a[g]),
      .hsel     (hsel_a[g]),
      .haddr    (haddr_a[g]),
      .htrans   (htrans_a[g]),
      .hwrite   (hwrite_a[g]),
      .hsize    (hsize_a[g]),
      .hburst   (hburst_a[g]),
      .hprot    (hprot_a[g]),
      .hwdata   (hwdata_a[g]),
      .hready   (hready_a[g]),
      .hreadyout(hreadyout_v[g]),
      .hresp    (hresp_v[g]),
      .hrdata   (hrdata_v[g])
    );
  end

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } txn_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  txn_t        txq[$];
  logic        rdy_log[$];
  logic [31:0] last_rdata;
  logic [7:0]  bmem [NI][65536];

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : k + 1;
  endfunction

  function automatic bit is_err(input logic [2:0] size, input logic [15:0] a);
    if (size > 3'd2) return 1'b1;
    return (int'(a) % (1 << size)) != 0;
  endfunction

  function automatic logic [31:0] model_read(input int k, input logic [15:0] a);
    int b;
    b = int'(a) & ~3;
    return {bmem[k][b+3], bmem[k][b+2], bmem[k][b+1], bmem[k][b]};
  endfunction

  task automatic model_write(input int k, input txn_t t);
    int a;
    a = int'(t.addr);
    for (int i = 0; i < (1 << t.size); i++) begin
      bmem[k][a+i] = t.wdata[8*((a+i)%4) +: 8];
    end
  endtask

  task automatic push_txn(input logic [15:0] a, input logic wr, input logic [2:0] sz,
                          input logic [31:0] d);
    txn_t t;
    t.addr = a; t.wr = wr; t.size = sz; t.wdata = d;
    txq.push_back(t);
  endtask

  // Pipelined master; enters and leaves at 1 time unit after a rising edge.
  task automatic run_txns(input int k);
    int          n, ai, di, dcyc, guard, ws;
    logic        rdy, exp_rdy;
    logic [1:0]  exp_resp, seen_resp;
    logic [31:0] exp_rdata, seen_rdata;
    bit          err;
    n = txq.size(); ai = 0; di = -1; dcyc = 0; guard = 0; ws = ws_of(k);
    err = 1'b0;
    rdy_log.delete();
    while ((ai < n || di >= 0) && guard < 40 + 12 * n) begin
      rdy = hreadyout_v[k];
      hready_a[k] = rdy;
      hburst_a[k] = 3'($urandom);
      if (ai < n) begin
        hsel_a[k] = 1'b1; htrans_a[k] = 2'b10; haddr_a[k] = txq[ai].addr;
        hwrite_a[k] = txq[ai].wr; hsize_a[k] = txq[ai].size;
      end else begin
        hsel_a[k] = 1'b0; htrans_a[k] = 2'b00;
      end
      hwdata_a[k] = (di >= 0) ? txq[di].wdata : 32'h0;
      if (di < 0) begin
        err = 1'b0; exp_rdy = 1'b1; exp_resp = 2'b00; exp_rdata = 32'h0;
      end else begin
        err       = is_err(txq[di].size, txq[di].addr);
        exp_rdy   = err ? (dcyc >= 1) : (dcyc >= ws);
        exp_resp  = err ? 2'b01 : 2'b00;
        exp_rdata = (!err && !txq[di].wr && exp_rdy) ? model_read(k, txq[di].addr) : 32'h0;
      end
      #1;
      seen_resp  = hresp_v[k];
      seen_rdata = hrdata_v[k];
      n_checks++;
      if (rdy !== exp_rdy)
        $display("FAIL hreadyout inst%0d t=%0t: got %b expected %b", k, $time, rdy, exp_rdy);
      else n_pass++;
      n_checks++;
      if (seen_resp !== exp_resp)
        $display("FAIL hresp inst%0d t=%0t: got %b expected %b", k, $time, seen_resp, exp_resp);
      else n_pass++;
      n_checks++;
      if (seen_rdata !== exp_rdata)
        $display("FAIL hrdata inst%0d t=%0t: got %h expected %h", k, $time, seen_rdata, exp_rdata);
      else n_pass++;
      rdy_log.push_back(rdy);
      @(posedge hclk);
      if (rdy) begin
        if (di >= 0 && !err) begin
          if (txq[di].wr) model_write(k, txq[di]);
          else last_rdata = seen_rdata;
        end
        if (ai < n) begin di = ai; ai++; end
        else di = -1;
        dcyc = 0;
      end else begin
        dcyc++;
      end
      #1;
      guard++;
    end
    if (ai < n || di >= 0) begin
      n_checks++;
      $display("FAIL run_txns timeout inst%0d: got %0d pending expected 0", k, n - ai + 1);
    end
    hsel_a[k] = 1'b0; htrans_a[k] = 2'b00; hready_a[k] = 1'b1; hwdata_a[k] = 32'h0;
    txq.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge hclk);
    #1;
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (hreadyout_v[k] !== 1'b1)
        $display("FAIL reset_hreadyout inst%0d: got %b expected 1", k, hreadyout_v[k]);
      else n_pass++;
      n_checks++;
      if (hresp_v[k] !== 2'b00)
        $display("FAIL reset_hresp inst%0d: got %b expected 00", k, hresp_v[k]);
      else n_pass++;
      n_checks++;
      if (hrdata_v[k] !== 32'h0)
        $display("FAIL reset_hrdata inst%0d: got %h expected 0", k, hrdata_v[k]);
      else n_pass++;
      hreset_a[k] = 1'b0;
    end
    @(posedge hclk);
    #1;
  endtask

  task automatic test_wait0_b2b();
    last_rdata = 32'h0;
    push_txn(16'h0010, 1'b1, 3'd2, 32'hDEADBEEF);
    push_txn(16'h0010, 1'b0, 3'd2, 32'h0);
    run_txns(0);
    n_checks++;
    if (last_rdata !== 32'hDEADBEEF)
      $display("FAIL b2b_rdata: got %h expected deadbeef", last_rdata);
    else n_pass++;
    n_checks++;
    if (rdy_log.size() != 3 || !(rdy_log[0] && rdy_log[1] && rdy_log[2]))
      $display("FAIL b2b_cycles: got %0d cycles expected 3 all ready", rdy_log.size());
    else n_pass++;
  endtask

  task automatic test_byte_lanes();
    last_rdata = 32'hFFFFFFFF;
    push_txn(16'h0020, 1'b1, 3'd2, 32'h00000000);
    push_txn(16'h0021, 1'b1, 3'd0, 32'h0000AA00);
    push_txn(16'h0022, 1'b1, 3'd1, 32'h12340000);
    push_txn(16'h0020, 1'b0, 3'd2, 32'h0);
    run_txns(0);
    n_checks++;
    if (last_rdata !== 32'h1234AA00)
      $display("FAIL byte_lanes: got %h expected 1234aa00", last_rdata);
    else n_pass++;
  endtask

  task automatic test_wait2_reads();
    logic [31:0] d0, d1;
    logic [5:0]  pat;
    bit          ok;
    d0 = $urandom; d1 = $urandom;
    push_txn(16'h0100, 1'b1, 3'd2, d0);
    push_txn(16'h0104, 1'b1, 3'd2, d1);
    run_txns(1);
    last_rdata = ~d1;
    push_txn(16'h0100, 1'b0, 3'd2, 32'h0);
    push_txn(16'h0104, 1'b0, 3'd2, 32'h0);
    run_txns(1);
    pat = 6'b001001;
    ok = (rdy_log.size() == 7);
    for (int i = 0; i < 6 && ok; i++) ok = (rdy_log[i+1] === pat[5-i]);
    n_checks++;
    if (!ok) $display("FAIL wait2_pattern: got %0d cycles expected 7 with 0,0,1,0,0,1", rdy_log.size());
    else n_pass++;
    n_checks++;
    if (last_rdata !== d1) $display("FAIL wait2_rdata: got %h expected %h", last_rdata, d1);
    else n_pass++;
  endtask

  task automatic test_errors(input int k);
    logic [31:0] d0, d1;
    int          exp_len;
    d0 = $urandom; d1 = $urandom;
    last_rdata = ~d1;
    push_txn(16'h0000, 1'b1, 3'd2, d0);
    push_txn(16'h0004, 1'b1, 3'd2, d1);
    push_txn(16'h0002, 1'b1, 3'd2, ~d0);
    push_txn(16'h0004, 1'b1, 3'd3, ~d1);
    push_txn(16'h0000, 1'b0, 3'd2, 32'h0);
    push_txn(16'h0004, 1'b0, 3'd2, 32'h0);
    run_txns(k);
    exp_len = 5 + 4 * (ws_of(k) + 1);
    n_checks++;
    if (rdy_log.size() != exp_len)
      $display("FAIL err_cycles inst%0d: got %0d expected %0d", k, rdy_log.size(), exp_len);
    else n_pass++;
    n_checks++;
    if (last_rdata !== d1) $display("FAIL err_ram inst%0d: got %h expected %h", k, last_rdata, d1);
    else n_pass++;
  endtask

  task automatic test_hready_low();
    logic [31:0] v;
    v = $urandom;
    push_txn(16'h0030, 1'b1, 3'd2, v);
    run_txns(0);
    hsel_a[0] = 1'b1; htrans_a[0] = 2'b10; hwrite_a[0] = 1'b1; haddr_a[0] = 16'h0030;
    hsize_a[0] = 3'd2; hready_a[0] = 1'b0; hwdata_a[0] = ~v;
    for (int i = 0; i < 3; i++) begin
      @(posedge hclk);
      #1;
      n_checks++;
      if (hreadyout_v[0] !== 1'b1 || hresp_v[0] !== 2'b00)
        $display("FAIL hready_low: got rdy=%b resp=%b expected rdy=1 resp=00", hreadyout_v[0], hresp_v[0]);
      else n_pass++;
    end
    hsel_a[0] = 1'b0; htrans_a[0] = 2'b00; hready_a[0] = 1'b1;
    @(posedge hclk);
    #1;
    last_rdata = ~v;
    push_txn(16'h0030, 1'b0, 3'd2, 32'h0);
    run_txns(0);
    n_checks++;
    if (last_rdata !== v) $display("FAIL hready_low_ram: got %h expected %h", last_rdata, v);
    else n_pass++;
  endtask

  task automatic test_reset_midwait();
    logic [31:0] old_v;
    old_v = $urandom | 32'h1;
    push_txn(16'h0040, 1'b1, 3'd2, old_v);
    run_txns(2);
    hsel_a[2] = 1'b1; htrans_a[2] = 2'b10; hwrite_a[2] = 1'b1; haddr_a[2] = 16'h0040; hsize_a[2] = 3'd2;
    @(posedge hclk);
    #1;
    hsel_a[2] = 1'b0; htrans_a[2] = 2'b00; hwdata_a[2] = ~old_v;
    n_checks++;
    if (hreadyout_v[2] !== 1'b0) $display("FAIL midwait_stall: got %b expected 0", hreadyout_v[2]);
    else n_pass++;
    @(posedge hclk);
    #3;
    hreset_a[2] = 1'b1;
    #1;
    n_checks++;
    if (hreadyout_v[2] !== 1'b1 || hresp_v[2] !== 2'b00 || hrdata_v[2] !== 32'h0)
      $display("FAIL midwait_reset: got rdy=%b resp=%b rdata=%h expected 1/00/0",
               hreadyout_v[2], hresp_v[2], hrdata_v[2]);
    else n_pass++;
    @(posedge hclk);
    #1;
    hreset_a[2] = 1'b0; hwdata_a[2] = 32'h0;
    hsel_a[2] = 1'b1; htrans_a[2] = 2'b10; hwrite_a[2] = 1'b0; haddr_a[2] = 16'h0040;
    @(posedge hclk);
    #1;
    hsel_a[2] = 1'b0; htrans_a[2] = 2'b00;
    repeat (3) @(posedge hclk);
    #1;
    n_checks++;
    if (hreadyout_v[2] !== 1'b1 || hrdata_v[2] !== old_v)
      $display("FAIL midwait_olddata: got rdy=%b rdata=%h expected 1/%h", hreadyout_v[2], hrdata_v[2], old_v);
    else n_pass++;
    #2;
    hreset_a[2] = 1'b1;
    #1;
    n_checks++;
    if (hrdata_v[2] !== 32'h0 || hreadyout_v[2] !== 1'b1)
      $display("FAIL lastcycle_reset: got rdata=%h rdy=%b expected 0/1", hrdata_v[2], hreadyout_v[2]);
    else n_pass++;
    @(posedge hclk);
    #1;
    hreset_a[2] = 1'b0;
  endtask

  task automatic test_random(input int k);
    int          base, off, r;
    logic [2:0]  sz;
    base = $urandom_range(64, 1000) << 6;
    for (int i = 0; i < 16; i++) push_txn(16'(base + 4 * i), 1'b1, 3'd2, $urandom);
    run_txns(k);
    for (int i = 0; i < 40; i++) begin
      r   = $urandom_range(0, 9);
      off = $urandom_range(0, 63);
      if (r < 3) sz = 3'd0;
      else if (r < 6) sz = 3'd1;
      else if (r < 9) sz = 3'd2;
      else sz = 3'($urandom_range(3, 7));
      if ($urandom_range(0, 4) != 0 && sz <= 3'd2) off = off & ~((1 << sz) - 1);
      push_txn(16'(base + off), 1'($urandom_range(0, 1)), sz, $urandom);
    end
    run_txns(k);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      hreset_a[k] = 1'b1; hsel_a[k] = 1'b0; haddr_a[k] = '0; htrans_a[k] = 2'b00;
      hwrite_a[k] = 1'b0; hsize_a[k] = 3'd0; hburst_a[k] = 3'd0; hprot_a[k] = 4'd0;
      hwdata_a[k] = '0; hready_a[k] = 1'b1;
    end
    last_rdata = 32'h0;
    test_reset();
    test_wait0_b2b();
    test_byte_lanes();
    test_wait2_reads();
    test_errors(0);
    test_errors(2);
    test_hready_low();
    test_reset_midwait();
    for (int k = 0; k < NI; k++) test_random(k);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
